execute: RTL
============

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have ports RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, input, 1 each, ID/EX control.
REQ-005 SHALL have ports ResultSrcE [1:0] and ALUControlE [3:0], input, result select and ALU opcode.
REQ-006 SHALL have ports RD1E, RD2E, ImmExtE, PCE, PCPlus4E, input, 32 each, operands and PC values.
REQ-007 SHALL have port RdE, input, 5, destination register.
REQ-008 SHALL have ports ForwardAE and ForwardBE, input, 2 each, forward select from the hazard unit.
REQ-009 SHALL have port ResultW, input, 32, writeback result for forwarding.
REQ-010 SHALL have ports PCSrcE (1) and PCTargetE (32), output, redirect request and target.
REQ-011 SHALL have port StallE, output, 1, high while the mul/div unit is busy.
REQ-012 SHALL have ports RegWriteM, MemWriteM (1), ResultSrcM (2), RdM (5), ALUResultM, WriteDataM, PCPlus4M (32), output, EX/MEM register.

Function
REQ-013 SHALL set SrcA from ForwardAE: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
REQ-014 SHALL select forwarded B (same encoding, RD2E) as WriteData; SrcB = ALUSrcE ? ImmExtE : forwarded B.
REQ-015 SHALL implement ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101 (signed), SLTU 0110, SLL 0111 (shamt SrcB[4:0]).
REQ-016 SHALL wrap all arithmetic modulo 2^32.
REQ-017 SHALL drive PCTargetE = PCE + ImmExtE and PCSrcE = JumpE | (BranchE & (SrcA == forwarded B)), combinationally.
REQ-018 SHALL load the EX/MEM register every cycle with a single-cycle op's result, forwarded B and the E-stage controls, one cycle of latency.
REQ-019 SHALL run MUL 1000 (low 32 bits), DIVU 1001 and REMU 1010 on the mul/div FSM with states IDLE, BUSY, DONE.
REQ-020 SHALL, in IDLE on an M opcode, capture SrcA/SrcB, go to BUSY, and assert StallE combinationally that cycle.
REQ-021 SHALL perform one shift-add or shift-subtract step per BUSY cycle, 32 cycles, then go to DONE.
REQ-022 SHALL, in DONE, deassert StallE, load the result and held controls into EX/MEM, and return to IDLE; total latency 34 cycles.
REQ-023 SHALL load a bubble (RegWriteM=0, MemWriteM=0, other fields 0) into EX/MEM on every cycle StallE is high.
REQ-024 SHALL produce DIVU quotient 0xFFFFFFFF and REMU remainder = dividend when the divisor is 0.
REQ-025 SHALL ignore ALUControlE changes while in BUSY; upstream holds ID/EX while StallE is high.

Reset
REQ-026 SHALL clear all M outputs to 0 and the FSM to IDLE on reset, StallE=0 next cycle.
REQ-027 SHALL abandon a BUSY operation on reset mid-operation, with no result written.

Configuration
REQ-028 SHALL, with RV_MULDIV_EN defined, include the mul/div FSM as specified.
REQ-029 SHALL, with RV_MULDIV_EN undefined, give opcodes 1000-1010 ALUResultM=0 in one cycle, tie StallE to 0 and instantiate no FSM.

Structure
REQ-030 SHALL place in shared package exec_pkg: ALU opcode constants, forward-select constants and the mul/div FSM state enum.
REQ-031 SHALL implement the iterative unit as sub-module muldiv_unit (start, op, a, b -> busy, done, result).

Verification
REQ-032 SHALL check: ADD with RD1E=5, ImmExtE=7, ALUSrcE=1 -> ALUResultM=12 one cycle later.
REQ-033 SHALL check: ForwardAE=10, ALUResultM=0x10, RD2E=0x10, BranchE=1 -> PCSrcE=1, PCTargetE=PCE+ImmExtE.
REQ-034 SHALL check: MUL 0x10000 x 0x10000 -> StallE high 33 cycles, bubbles in EX/MEM, then ALUResultM=0.
REQ-035 SHALL check: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF.
REQ-036 SHALL check: reset asserted at BUSY cycle 10 -> IDLE, StallE=0, RegWriteM=0, no result written.
REQ-037 SHALL check: SUB 3-5 -> 0xFFFFFFFE; SLT(-1,1)=1; SLTU(0xFFFFFFFF,1)=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forward selects and
// the iterative mul/div state encoding.
package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REMU = 4'b1010;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MUL / DIVU / REMU unit: one shift-add or restoring-divide step per
// BUSY cycle, 32 steps. Only built when RV_MULDIV_EN is defined.
`ifdef RV_MULDIV_EN
module muldiv_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;  // MUL: partial product, DIV: remainder
  logic [XLEN-1:0] a_q, a_d;      // MUL: multiplicand, DIV: dividend/quotient
  logic [XLEN-1:0] b_q, b_d;      // MUL: multiplier, DIV: divisor
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_shift = {acc_q, a_q[XLEN-1]};
    diff      = rem_shift - {1'b0, b_q};
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = 5'd0;
          op_d    = op;
          acc_d   = '0;
          a_d     = a;
          b_d     = b;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (op_q == ALU_MUL) begin
          if (b_q[0]) begin
            acc_d = acc_q + a_q;
          end else begin
            acc_d = acc_q;
          end
          a_d = {a_q[XLEN-2:0], 1'b0};
          b_d = {1'b0, b_q[XLEN-1:1]};
        end else begin
          // diff never reaches bit XLEN when rem_shift >= divisor, so its top bit is the borrow
          if (!diff[XLEN]) begin
            acc_d = diff[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = rem_shift[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b0};
          end
        end
        if (cnt_q == 5'd31) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    case (op_q)
      ALU_MUL:  result = acc_q;
      ALU_DIVU: result = a_q;
      default:  result = acc_q;
    endcase
  end

  assign busy = ((state_q == MD_IDLE) && start) || (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);

endmodule
`endif

// File: rtl/execute.sv
// Pipeline execute stage with forwarding, branch resolution and EX/MEM register.
// Define RV_MULDIV_EN to add the iterative MUL/DIVU/REMU unit (stalls 33 cycles).
module execute
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result;
  logic            h_reg_write, h_mem_write;
  logic [1:0]      h_result_src;
  logic [4:0]      h_rd;
  logic [XLEN-1:0] h_write_data, h_pc_plus4;

  logic            reg_write_q, reg_write_d, mem_write_q, mem_write_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d, write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = RD2E;
    endcase
    if (ALUSrcE) begin
      src_b = ImmExtE;
    end else begin
      src_b = fwd_b;
    end
  end

  always_comb begin
    case (ALUControlE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_result = src_a << src_b[4:0];
      default:  alu_result = '0;
    endcase
  end

  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & (src_a == fwd_b));

`ifdef RV_MULDIV_EN
  logic            stall_q, stall_d;
  logic            h_reg_write_q, h_reg_write_d, h_mem_write_q, h_mem_write_d;
  logic [1:0]      h_result_src_q, h_result_src_d;
  logic [4:0]      h_rd_q, h_rd_d;
  logic [XLEN-1:0] h_write_data_q, h_write_data_d, h_pc_plus4_q, h_pc_plus4_d;

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (is_muldiv_op(ALUControlE)),
    .op     (ALUControlE),
    .a      (src_a),
    .b      (src_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // The first stalled cycle is the one the unit accepted the operation in
  always_comb begin
    stall_d = md_busy;
    if (md_busy && !stall_q) begin
      h_reg_write_d  = RegWriteE;
      h_mem_write_d  = MemWriteE;
      h_result_src_d = ResultSrcE;
      h_rd_d         = RdE;
      h_write_data_d = fwd_b;
      h_pc_plus4_d   = PCPlus4E;
    end else begin
      h_reg_write_d  = h_reg_write_q;
      h_mem_write_d  = h_mem_write_q;
      h_result_src_d = h_result_src_q;
      h_rd_d         = h_rd_q;
      h_write_data_d = h_write_data_q;
      h_pc_plus4_d   = h_pc_plus4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q        <= 1'b0;
      h_reg_write_q  <= 1'b0;
      h_mem_write_q  <= 1'b0;
      h_result_src_q <= 2'd0;
      h_rd_q         <= 5'd0;
      h_write_data_q <= '0;
      h_pc_plus4_q   <= '0;
    end else begin
      stall_q        <= stall_d;
      h_reg_write_q  <= h_reg_write_d;
      h_mem_write_q  <= h_mem_write_d;
      h_result_src_q <= h_result_src_d;
      h_rd_q         <= h_rd_d;
      h_write_data_q <= h_write_data_d;
      h_pc_plus4_q   <= h_pc_plus4_d;
    end
  end

  assign h_reg_write  = h_reg_write_q;
  assign h_mem_write  = h_mem_write_q;
  assign h_result_src = h_result_src_q;
  assign h_rd         = h_rd_q;
  assign h_write_data = h_write_data_q;
  assign h_pc_plus4   = h_pc_plus4_q;
`else
  assign md_busy      = 1'b0;
  assign md_done      = 1'b0;
  assign md_result    = '0;
  assign h_reg_write  = 1'b0;
  assign h_mem_write  = 1'b0;
  assign h_result_src = 2'd0;
  assign h_rd         = 5'd0;
  assign h_write_data = '0;
  assign h_pc_plus4   = '0;
`endif

  assign StallE = md_busy;

  // Stalled cycles push a bubble; the DONE cycle commits the held instruction
  always_comb begin
    if (md_busy) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'd0;
      rd_d         = 5'd0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
    end else if (md_done) begin
      reg_write_d  = h_reg_write;
      mem_write_d  = h_mem_write;
      result_src_d = h_result_src;
      rd_d         = h_rd;
      alu_result_d = md_result;
      write_data_d = h_write_data;
      pc_plus4_d   = h_pc_plus4;
    end else begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      rd_d         = RdE;
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = PCPlus4E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'd0;
      rd_q         <= 5'd0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RdM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule
